// File: rtl/dispense_decoder_pkg.sv
// Shared types and constant helpers for the dispense decoder.
// The state encoding matches the control FSM's view of the dispense path.
package dispense_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DRIVE      = 2'd1,
    ST_WAIT_SENSE = 2'd2,
    ST_GAP        = 2'd3
  } state_e;

  // Bits needed to hold values 0..value-1. Never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dispense_decoder_onehot.sv
// Binary-to-one-hot decoder with enable; inverse of the product-select encoder.
// All outputs are zero when the enable is low.
module onehot_decoder #(
  parameter int N = 2
) (
  input  logic [N-1:0]      code_i,
  input  logic              en_i,
  output logic [2**N-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/dispense_decoder.sv
// Dispense sequencer: accepts an item code, pulses one motor line, waits for the
// drop sensor and reports done or fault, then enforces a cool-down gap.
module dispense_decoder
  import dispense_decoder_pkg::*;
#(
  parameter int N              = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int GAP_CYCLES     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_valid,
  input  logic [N-1:0]      sel_code,
  output logic              sel_ready,
  output logic [2**N-1:0]   motor_en,
  input  logic              item_sensed,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [N-1:0]      last_code
);

  localparam int M     = 2**N;
  localparam int CNT_W = clog2(max3(PULSE_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sensed_q, sensed_d;
  logic [M-1:0]     motor_q, motor_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [N-1:0]     last_q, last_d;
  logic             accept;
  logic [M-1:0]     dec_onehot;

  // Handshake: a code transfers on a rising edge where sel_valid && sel_ready;
  // sel_ready is high only in IDLE and sel_code is ignored at all other times.
  assign sel_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = sel_valid && sel_ready;

  onehot_decoder #(.N(N)) u_onehot (
    .code_i   (sel_code),
    .en_i     (accept),
    .onehot_o (dec_onehot)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sensed_d = sensed_q;
    motor_d  = '0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_DRIVE;
          cnt_d    = '0;
          sensed_d = 1'b0;
          motor_d  = dec_onehot;
          last_d   = sel_code;
        end
      end
      ST_DRIVE: begin
        if (item_sensed) sensed_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_SENSE;
          cnt_d   = '0;
        end else begin
          motor_d = motor_q;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_SENSE: begin
        // Sense is checked before the timeout so a same-cycle collision reports done.
        if (sensed_q || item_sensed) begin
          done_d   = 1'b1;
          state_d  = ST_GAP;
          cnt_d    = '0;
          sensed_d = 1'b0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d  = 1'b1;
          state_d  = ST_GAP;
          cnt_d    = '0;
          sensed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        sensed_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sensed_q <= 1'b0;
      motor_q  <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sensed_q <= sensed_d;
      motor_q  <= motor_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      last_q   <= last_d;
    end
  end

  assign motor_en  = motor_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign last_code = last_q;

endmodule

// File: tb/tb_dispense_decoder.sv
// Self-checking bench for dispense_decoder with default parameters.
// Cycle k counts clock periods after the accept edge (k=0 is the first one).
module tb_dispense_decoder;

  localparam int N = 2;
  localparam int M = 4;

  logic         clk;
  logic         rst_n;
  logic         sel_valid;
  logic [N-1:0] sel_code;
  logic         sel_ready;
  logic [M-1:0] motor_en;
  logic         item_sensed;
  logic         busy;
  logic         done;
  logic         fault;
  logic [N-1:0] last_code;

  int n_checks;
  int n_fail;

  // {fault, done, last_code} expected at each done/fault pulse
  logic [N+1:0] exp_q[$];

  dispense_decoder #(
    .N(N), .PULSE_CYCLES(4), .TIMEOUT_CYCLES(16), .GAP_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel_valid   (sel_valid),
    .sel_code    (sel_code),
    .sel_ready   (sel_ready),
    .motor_en    (motor_en),
    .item_sensed (item_sensed),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .last_code   (last_code)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / invariant monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ($countones(motor_en) > 1 || (motor_en != '0 && !busy)) begin
        n_fail++;
        $display("FAIL motor_invariant: motor_en=%b busy=%b", motor_en, busy);
      end
      n_checks++;
      if (done && fault) begin
        n_fail++;
        $display("FAIL done_fault_exclusive: done=%b fault=%b required not both", done, fault);
      end
      if (done || fault) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: done=%b fault=%b last_code=%0d required no pulse",
                   done, fault, last_code);
        end else begin
          logic [N+1:0] e;
          e = exp_q.pop_front();
          if ({fault, done, last_code} !== e) begin
            n_fail++;
            $display("FAIL result: got {fault,done,code}=%b required %b",
                     {fault, done, last_code}, e);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run_dispense(input logic [N-1:0] code, input int s_on, input int s_off,
                              input int max_k,
                              output int done_k, output int fault_k, output int ready_k,
                              output int first_k, output int drive_cyc,
                              output logic [M-1:0] motor_seen, output logic stable,
                              output int n_done, output int n_fault);
    done_k = -1; fault_k = -1; ready_k = -1; first_k = -1; drive_cyc = 0;
    motor_seen = '0; stable = 1'b1; n_done = 0; n_fault = 0;
    @(negedge clk);
    sel_valid = 1'b1;
    sel_code = code;
    item_sensed = 1'b0;
    @(posedge clk);
    #1;
    sel_valid = 1'b0;
    sel_code = ~code;
    for (int k = 0; k < max_k; k++) begin
      item_sensed = (k >= s_on) && (k < s_off);
      @(negedge clk);
      if (motor_en != '0) begin
        drive_cyc++;
        if (first_k < 0) begin
          first_k = k;
          motor_seen = motor_en;
        end else if (motor_en != motor_seen) begin
          stable = 1'b0;
        end
      end
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (fault) begin
        n_fault++;
        if (fault_k < 0) fault_k = k;
      end
      if (sel_ready && ready_k < 0) ready_k = k;
      @(posedge clk);
      #1;
    end
    item_sensed = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sel_valid = 1'b0;
    sel_code = '0;
    item_sensed = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (motor_en !== 4'b0000) begin n_fail++; $display("FAIL reset_motor: got %b required 0000", motor_en); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b required 0", fault); end
    n_checks++; if (last_code !== 2'd0) begin n_fail++; $display("FAIL reset_last_code: got %0d required 0", last_code); end
    n_checks++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", sel_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
  endtask

  task automatic test_basic();
    int dk, fk, rk, f1, dc, nd, nf;
    logic [M-1:0] ms;
    logic st;
    exp_q.push_back({1'b0, 1'b1, 2'd2});
    // sensor rises in the second WAIT_SENSE cycle (k=5)
    run_dispense(2'd2, 5, 7, 12, dk, fk, rk, f1, dc, ms, st, nd, nf);
    n_checks++; if (ms !== 4'b0100) begin n_fail++; $display("FAIL basic_motor: got %b required 0100", ms); end
    n_checks++; if (dc != 4 || f1 != 0) begin n_fail++; $display("FAIL basic_pulse: got %0d cycles from k=%0d required 4 from k=0", dc, f1); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL basic_stable: got changing motor_en required constant"); end
    n_checks++; if (dk != 6 || nd != 1 || nf != 0) begin n_fail++; $display("FAIL basic_done: got k=%0d n=%0d faults=%0d required k=6 n=1 faults=0", dk, nd, nf); end
    n_checks++; if (last_code !== 2'd2) begin n_fail++; $display("FAIL basic_last_code: got %0d required 2", last_code); end
    n_checks++; if (rk != 8) begin n_fail++; $display("FAIL basic_ready: got k=%0d required k=8", rk); end
  endtask

  task automatic test_timeout();
    int dk, fk, rk, f1, dc, nd, nf;
    logic [M-1:0] ms;
    logic st;
    exp_q.push_back({1'b1, 1'b0, 2'd3});
    run_dispense(2'd3, 100, 100, 24, dk, fk, rk, f1, dc, ms, st, nd, nf);
    n_checks++; if (ms !== 4'b1000 || dc != 4) begin n_fail++; $display("FAIL timeout_motor: got %b for %0d cycles required 1000 for 4", ms, dc); end
    n_checks++; if (fk != 20 || nf != 1) begin n_fail++; $display("FAIL timeout_fault: got k=%0d n=%0d required k=20 n=1", fk, nf); end
    n_checks++; if (nd != 0) begin n_fail++; $display("FAIL timeout_no_done: got %0d done pulses required 0", nd); end
    n_checks++; if (rk != 22) begin n_fail++; $display("FAIL timeout_ready: got k=%0d required k=22", rk); end
  endtask

  task automatic test_early_sense();
    int dk, fk, rk, f1, dc, nd, nf;
    logic [M-1:0] ms;
    logic st;
    exp_q.push_back({1'b0, 1'b1, 2'd0});
    // one-cycle pulse in the second DRIVE cycle
    run_dispense(2'd0, 1, 2, 10, dk, fk, rk, f1, dc, ms, st, nd, nf);
    n_checks++; if (ms !== 4'b0001 || dc != 4) begin n_fail++; $display("FAIL early_motor: got %b for %0d cycles required 0001 for 4", ms, dc); end
    n_checks++; if (dk != 5 || nd != 1) begin n_fail++; $display("FAIL early_done: got k=%0d n=%0d required k=5 n=1", dk, nd); end
    n_checks++; if (nf != 0) begin n_fail++; $display("FAIL early_no_fault: got %0d faults required 0", nf); end
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] exp_m;
    logic [M-1:0] mot_a[16];
    logic         rdy_a[16];
    exp_q.push_back({1'b0, 1'b1, 2'd1});
    exp_q.push_back({1'b0, 1'b1, 2'd2});
    @(negedge clk);
    sel_valid = 1'b1;
    sel_code = 2'd1;
    item_sensed = 1'b1;
    @(posedge clk);
    #1;
    sel_code = 2'd2;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) sel_valid = 1'b0;
      @(negedge clk);
      mot_a[k] = motor_en;
      rdy_a[k] = sel_ready;
      @(posedge clk);
      #1;
    end
    item_sensed = 1'b0;
    for (int k = 0; k < 16; k++) begin
      exp_m = (k < 4) ? 4'b0010 : ((k >= 8 && k < 12) ? 4'b0100 : 4'b0000);
      n_checks++;
      if (mot_a[k] !== exp_m) begin
        n_fail++;
        $display("FAIL b2b_motor_k%0d: got %b required %b", k, mot_a[k], exp_m);
      end
    end
    n_checks++; if (rdy_a[6] !== 1'b0 || rdy_a[7] !== 1'b1 || rdy_a[8] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready: got k6=%b k7=%b k8=%b required 0 1 0", rdy_a[6], rdy_a[7], rdy_a[8]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int nd, nf;
    nd = 0; nf = 0;
    @(negedge clk);
    sel_valid = 1'b1;
    sel_code = 2'd1;
    @(posedge clk);
    #1;
    sel_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (motor_en !== 4'b0010) begin n_fail++; $display("FAIL areset_pre_motor: got %b required 0010", motor_en); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (motor_en !== 4'b0000) begin n_fail++; $display("FAIL areset_motor: got %b required 0000", motor_en); end
    n_checks++; if (sel_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_state: got ready=%b busy=%b required 1 0", sel_ready, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (fault) nf++;
    end
    n_checks++; if (nd != 0 || nf != 0) begin n_fail++; $display("FAIL areset_no_pulse: got done=%0d fault=%0d required 0 0", nd, nf); end
    n_checks++; if (sel_ready !== 1'b1 || motor_en !== 4'b0000) begin n_fail++; $display("FAIL areset_idle: got ready=%b motor=%b required 1 0000", sel_ready, motor_en); end
  endtask

  task automatic test_collision();
    int dk, fk, rk, f1, dc, nd, nf;
    logic [M-1:0] ms;
    logic st;
    exp_q.push_back({1'b0, 1'b1, 2'd1});
    // sensor rises on the last WAIT_SENSE cycle before the timeout (k=19)
    run_dispense(2'd1, 19, 20, 24, dk, fk, rk, f1, dc, ms, st, nd, nf);
    n_checks++; if (dk != 20 || nd != 1) begin n_fail++; $display("FAIL collision_done: got k=%0d n=%0d required k=20 n=1", dk, nd); end
    n_checks++; if (nf != 0) begin n_fail++; $display("FAIL collision_no_fault: got %0d faults required 0", nf); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_timeout();
    test_early_sense();
    test_back_to_back();
    test_async_reset();
    test_collision();
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending results required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
